// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI4 slave backed by a single-port word SRAM.
// Independent write (AW/W/B) and read (AR/R) FSMs; FIXED/INCR bursts,
// byte strobes, narrow transfers, SLVERR/DECERR responses.
// Optional feature macro AXI_SRAM_ACC_CNT_EN adds saturating W/R beat counters.
module axi_sram_slave #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [ID_W-1:0]     s_awid,
  input  logic [ADDR_W-1:0]   s_awaddr,
  input  logic [7:0]          s_awlen,
  input  logic [2:0]          s_awsize,
  input  logic [1:0]          s_awburst,
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_wvalid,
  input  logic                s_wlast,
  output logic                s_wready,
  output logic [ID_W-1:0]     s_bid,
  output logic [2:0]          s_bresp,
  output logic                s_bvalid,
  input  logic                s_bready,
  input  logic [ID_W-1:0]     s_arid,
  input  logic [ADDR_W-1:0]   s_araddr,
  input  logic [7:0]          s_arlen,
  input  logic [1:0]          s_arburst,
  input  logic [2:0]          s_arsize,
  input  logic                s_arvalid,
  output logic                s_arready,
  output logic [ID_W-1:0]     s_rid,
  output logic [DATA_W-1:0]   s_rdata,
  output logic [2:0]          s_rresp,
  output logic                s_rvalid,
  output logic                s_rlast,
  input  logic                s_rready
`ifdef AXI_SRAM_ACC_CNT_EN
  ,
  output logic [31:0]         wr_beats_o,
  output logic [31:0]         rd_beats_o
`endif
);
  localparam int NB = DATA_W / 8;
  localparam int LG = $clog2(NB);
  localparam int IW = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH * NB);
  localparam logic [1:0] OKAY = 2'd0, SLVERR = 2'd2, DECERR = 2'd3;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_e;

  logic [DATA_W-1:0] mem [DEPTH];

  // Response codes are ordered so the numerically larger one is the worse one.
  function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  // WRAP, the reserved burst encoding and over-wide beats are all unsupported.
  function automatic logic [1:0] hdr_err(input logic [2:0] size, input logic [1:0] burst);
    return (burst[1] || size > 3'(LG)) ? SLVERR : OKAY;
  endfunction

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                  input logic [2:0] size, input logic [1:0] burst);
    return (burst == 2'b01) ? a + (ADDR_W'(1) << size) : a;
  endfunction

  // ---------------- write channel ----------------
  w_state_e          w_state_q, w_state_d;
  logic [ID_W-1:0]   wid_q, wid_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [7:0]        wlen_q, wlen_d;
  logic [2:0]        wsize_q, wsize_d;
  logic [1:0]        wburst_q, wburst_d;
  logic [8:0]        wcnt_q, wcnt_d;
  logic [1:0]        werr_q, werr_d, wbeat_err;
  logic              wr_en;

  // Write FSM next state: latch AW, accept one beat per cycle, then hold B
  always_comb begin
    w_state_d = w_state_q;
    wid_d     = wid_q;
    waddr_d   = waddr_q;
    wlen_d    = wlen_q;
    wsize_d   = wsize_q;
    wburst_d  = wburst_q;
    wcnt_d    = wcnt_q;
    werr_d    = werr_q;
    wr_en     = 1'b0;
    wbeat_err = worst(werr_q, (waddr_q >= LIMIT) ? DECERR : OKAY);
    case (w_state_q)
      W_IDLE: if (s_awvalid) begin
        wid_d     = s_awid;
        waddr_d   = s_awaddr;
        wlen_d    = s_awlen;
        wsize_d   = s_awsize;
        wburst_d  = s_awburst;
        wcnt_d    = '0;
        werr_d    = hdr_err(s_awsize, s_awburst);
        w_state_d = W_DATA;
      end
      W_DATA: if (s_wvalid) begin
        wr_en   = (wbeat_err == OKAY) && !rst_i;
        werr_d  = wbeat_err;
        waddr_d = next_addr(waddr_q, wsize_q, wburst_q);
        wcnt_d  = wcnt_q + 9'd1;
        if (s_wlast) begin
          // wlast ends the burst; a length disagreement with awlen is reported
          if (wcnt_q != {1'b0, wlen_q}) werr_d = worst(wbeat_err, SLVERR);
          w_state_d = W_RESP;
        end
      end
      W_RESP: if (s_bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write channel registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_state_q <= W_IDLE;
      wid_q     <= '0;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wsize_q   <= '0;
      wburst_q  <= '0;
      wcnt_q    <= '0;
      werr_q    <= OKAY;
    end else begin
      w_state_q <= w_state_d;
      wid_q     <= wid_d;
      waddr_q   <= waddr_d;
      wlen_q    <= wlen_d;
      wsize_q   <= wsize_d;
      wburst_q  <= wburst_d;
      wcnt_q    <= wcnt_d;
      werr_q    <= werr_d;
    end
  end

  // Byte-lane write into the array (contents are never reset)
  always_ff @(posedge clk_i) begin
    if (wr_en)
      for (int i = 0; i < NB; i++)
        if (s_wstrb[i]) mem[waddr_q[LG +: IW]][8*i +: 8] <= s_wdata[8*i +: 8];
  end

  assign s_awready = (w_state_q == W_IDLE) && !rst_i;
  assign s_wready  = (w_state_q == W_DATA) && !rst_i;
  assign s_bvalid  = (w_state_q == W_RESP) && !rst_i;
  assign s_bid     = wid_q;
  assign s_bresp   = {1'b0, werr_q};

  // ---------------- read channel ----------------
  r_state_e          r_state_q, r_state_d;
  logic [ID_W-1:0]   rid_q, rid_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [7:0]        rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic [2:0]        rsize_q, rsize_d;
  logic [1:0]        rburst_q, rburst_d;
  logic [1:0]        rerr_q, rerr_d, rbeat_err, rresp_q, rresp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rlast_q, rlast_d;

  // Read FSM next state: fetch sees the array before any same-edge write lands
  always_comb begin
    r_state_d = r_state_q;
    rid_d     = rid_q;
    raddr_d   = raddr_q;
    rlen_d    = rlen_q;
    rsize_d   = rsize_q;
    rburst_d  = rburst_q;
    rcnt_d    = rcnt_q;
    rerr_d    = rerr_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    rlast_d   = rlast_q;
    rbeat_err = worst(rerr_q, (raddr_q >= LIMIT) ? DECERR : OKAY);
    case (r_state_q)
      R_IDLE: if (s_arvalid) begin
        rid_d     = s_arid;
        raddr_d   = s_araddr;
        rlen_d    = s_arlen;
        rsize_d   = s_arsize;
        rburst_d  = s_arburst;
        rcnt_d    = '0;
        rerr_d    = hdr_err(s_arsize, s_arburst);
        r_state_d = R_FETCH;
      end
      R_FETCH: begin
        rerr_d    = rbeat_err;
        rresp_d   = rbeat_err;
        rdata_d   = (rbeat_err == OKAY) ? mem[raddr_q[LG +: IW]] : '0;
        rlast_d   = (rcnt_q == rlen_q);
        r_state_d = R_DATA;
      end
      R_DATA: if (s_rready) begin
        if (rlast_q) r_state_d = R_IDLE;
        else begin
          raddr_d   = next_addr(raddr_q, rsize_q, rburst_q);
          rcnt_d    = rcnt_q + 8'd1;
          r_state_d = R_FETCH;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read channel registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state_q <= R_IDLE;
      rid_q     <= '0;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rsize_q   <= '0;
      rburst_q  <= '0;
      rcnt_q    <= '0;
      rerr_q    <= OKAY;
      rresp_q   <= OKAY;
      rdata_q   <= '0;
      rlast_q   <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      rid_q     <= rid_d;
      raddr_q   <= raddr_d;
      rlen_q    <= rlen_d;
      rsize_q   <= rsize_d;
      rburst_q  <= rburst_d;
      rcnt_q    <= rcnt_d;
      rerr_q    <= rerr_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      rlast_q   <= rlast_d;
    end
  end

  assign s_arready = (r_state_q == R_IDLE) && !rst_i;
  assign s_rvalid  = (r_state_q == R_DATA) && !rst_i;
  assign s_rid     = rid_q;
  assign s_rdata   = rdata_q;
  assign s_rresp   = {1'b0, rresp_q};
  assign s_rlast   = rlast_q;

`ifdef AXI_SRAM_ACC_CNT_EN
  logic [31:0] wr_beats_q, wr_beats_d, rd_beats_q, rd_beats_d;

  // Saturating W/R handshake counters, error beats included
  always_comb begin
    wr_beats_d = wr_beats_q;
    rd_beats_d = rd_beats_q;
    if (s_wvalid && s_wready && !(&wr_beats_q)) wr_beats_d = wr_beats_q + 32'd1;
    if (s_rvalid && s_rready && !(&rd_beats_q)) rd_beats_d = rd_beats_q + 32'd1;
  end

  // Counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_beats_q <= '0;
      rd_beats_q <= '0;
    end else begin
      wr_beats_q <= wr_beats_d;
      rd_beats_q <= rd_beats_d;
    end
  end

  assign wr_beats_o = wr_beats_q;
  assign rd_beats_o = rd_beats_q;
`endif
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: scoreboard bench for axi_sram_slave.
// Expected read beats are queued when a burst is issued and popped as beats return.
module tb_axi_sram_slave;
  localparam int BOUND = 200;
  localparam logic [31:0] TOP = 32'd4096; // DEPTH*4

  logic        clk_i = 1'b0, rst_i = 1'b1;
  logic [3:0]  s_awid, s_bid, s_arid, s_rid;
  logic [31:0] s_awaddr, s_araddr, s_wdata, s_rdata;
  logic [7:0]  s_awlen, s_arlen;
  logic [2:0]  s_awsize, s_arsize, s_bresp, s_rresp;
  logic [1:0]  s_awburst, s_arburst;
  logic [3:0]  s_wstrb;
  logic s_awvalid, s_awready, s_wvalid, s_wlast, s_wready, s_bvalid, s_bready;
  logic s_arvalid, s_arready, s_rvalid, s_rlast, s_rready;
`ifdef AXI_SRAM_ACC_CNT_EN
  logic [31:0] wr_beats_o, rd_beats_o;
`endif

  axi_sram_slave dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wlast(s_wlast),
    .s_wready(s_wready), .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid),
    .s_bready(s_bready), .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_arburst(s_arburst), .s_arsize(s_arsize), .s_arvalid(s_arvalid),
    .s_arready(s_arready), .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rvalid(s_rvalid), .s_rlast(s_rlast), .s_rready(s_rready)
`ifdef AXI_SRAM_ACC_CNT_EN
    , .wr_beats_o(wr_beats_o), .rd_beats_o(rd_beats_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed { logic [31:0] data; logic [2:0] resp; logic last; } beat_t;
  beat_t       exp_q[$], got_q[$];
  logic [31:0] wd_q[$];
  logic [3:0]  ws_q[$];
  int vecs = 0, errs = 0;

  function automatic beat_t bt(input logic [31:0] d, input logic [2:0] r, input logic l);
    return {d, r, l};
  endfunction

  task automatic tmo(input string what);
    vecs++; errs++;
    $display("FAIL timeout %s: got no handshake in %0d cycles, required one", what, BOUND);
  endtask

  // Drives AW, the beats in wd_q/ws_q, then takes B with bready high.
  task automatic drv_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           output logic [2:0] resp, output logic [3:0] bid);
    int n;
    s_awid = id; s_awaddr = addr; s_awlen = len; s_awsize = size; s_awburst = burst;
    s_awvalid = 1'b1;
    n = 0; while (!s_awready && n < BOUND) begin @(negedge clk_i); n++; end
    if (n >= BOUND) tmo("aw");
    @(negedge clk_i); s_awvalid = 1'b0;
    for (int b = 0; b < wd_q.size(); b++) begin
      s_wvalid = 1'b1; s_wdata = wd_q[b]; s_wstrb = ws_q[b]; s_wlast = (b == wd_q.size() - 1);
      n = 0; while (!s_wready && n < BOUND) begin @(negedge clk_i); n++; end
      if (n >= BOUND) tmo("w");
      @(negedge clk_i);
    end
    s_wvalid = 1'b0; s_wlast = 1'b0; s_bready = 1'b1;
    n = 0; while (!s_bvalid && n < BOUND) begin @(negedge clk_i); n++; end
    if (n >= BOUND) tmo("b");
    resp = s_bresp; bid = s_bid;
    @(negedge clk_i); s_bready = 1'b0;
  endtask

  // Drives AR and collects len+1 beats into got_q with rready high.
  task automatic drv_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, output logic [3:0] rid);
    int n;
    got_q.delete();
    s_arid = id; s_araddr = addr; s_arlen = len; s_arsize = size; s_arburst = burst;
    s_arvalid = 1'b1;
    n = 0; while (!s_arready && n < BOUND) begin @(negedge clk_i); n++; end
    if (n >= BOUND) tmo("ar");
    @(negedge clk_i); s_arvalid = 1'b0; s_rready = 1'b1;
    rid = 4'hx;
    for (int b = 0; b <= int'(len); b++) begin
      n = 0; while (!s_rvalid && n < BOUND) begin @(negedge clk_i); n++; end
      if (n >= BOUND) tmo("r");
      got_q.push_back(bt(s_rdata, s_rresp, s_rlast)); rid = s_rid;
      @(negedge clk_i);
    end
    s_rready = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk_i);
    vecs++;
    if ({s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rlast} !== 6'b0) begin
      errs++; $display("FAIL reset_hs: got %b, required 000000",
                       {s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rlast});
    end
    vecs++;
    if ({s_bid, s_bresp, s_rid, s_rresp, s_rdata} !== 46'd0) begin
      errs++; $display("FAIL reset_data: got bid=%h bresp=%h rid=%h rresp=%h rdata=%h, required 0",
                       s_bid, s_bresp, s_rid, s_rresp, s_rdata);
    end
    rst_i = 1'b0; #1;
    vecs++;
    if ({s_awready, s_arready} !== 2'b11) begin
      errs++; $display("FAIL reset_release: got aw/ar ready %b, required 11", {s_awready, s_arready});
    end
    @(negedge clk_i);
  endtask

  task automatic test_incr;
    logic [2:0] resp; logic [3:0] id; beat_t e;
    wd_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3}; ws_q = '{4'hF, 4'hF, 4'hF, 4'hF};
    drv_write(4'h5, 32'h10, 8'd3, 3'd2, 2'b01, resp, id);
    vecs++;
    if ({resp, id} !== {3'd0, 4'h5}) begin
      errs++; $display("FAIL incr_b: got bresp=%0d bid=%h, required 0 / 5", resp, id);
    end
    for (int b = 0; b < 4; b++) exp_q.push_back(bt(32'hA0 + b, 3'd0, b == 3));
    drv_read(4'h9, 32'h10, 8'd3, 3'd2, 2'b01, id);
    vecs++;
    if (id !== 4'h9) begin errs++; $display("FAIL incr_rid: got %h, required 9", id); end
    for (int b = 0; exp_q.size() > 0; b++) begin
      e = exp_q.pop_front(); vecs++;
      if (got_q[b] !== e) begin
        errs++; $display("FAIL incr_r beat %0d: got %h, required %h", b, got_q[b], e);
      end
    end
  endtask

  task automatic test_strobe;
    logic [2:0] resp; logic [3:0] id; beat_t e;
    wd_q = '{32'h11223344}; ws_q = '{4'hF};
    drv_write(4'h1, 32'h20, 8'd0, 3'd2, 2'b01, resp, id);
    wd_q = '{32'hFFFFFFFF}; ws_q = '{4'h2};
    drv_write(4'h1, 32'h20, 8'd0, 3'd2, 2'b01, resp, id);
    exp_q.push_back(bt(32'h1122FF44, 3'd0, 1'b1));
    // narrow byte beats walk the lanes of one word
    wd_q = '{32'h10101010, 32'h11111111, 32'h12121212, 32'h13131313};
    ws_q = '{4'h1, 4'h2, 4'h4, 4'h8};
    drv_write(4'h2, 32'h24, 8'd3, 3'd0, 2'b01, resp, id);
    vecs++;
    if (resp !== 3'd0) begin errs++; $display("FAIL narrow_b: got bresp=%0d, required 0", resp); end
    exp_q.push_back(bt(32'h13121110, 3'd0, 1'b1));
    for (int k = 0; exp_q.size() > 0; k++) begin
      drv_read(4'h0, 32'h20 + 4 * k, 8'd0, 3'd2, 2'b01, id);
      e = exp_q.pop_front(); vecs++;
      if (got_q[0] !== e) begin
        errs++; $display("FAIL strobe_r %0d: got %h, required %h", k, got_q[0], e);
      end
    end
  endtask

  task automatic test_errors;
    logic [2:0] resp; logic [3:0] id; beat_t e;
    exp_q.push_back(bt(32'h0, 3'd3, 1'b0)); exp_q.push_back(bt(32'h0, 3'd3, 1'b1));
    drv_read(4'h3, TOP, 8'd1, 3'd2, 2'b01, id);
    for (int b = 0; exp_q.size() > 0; b++) begin
      e = exp_q.pop_front(); vecs++;
      if (got_q[b] !== e) begin errs++; $display("FAIL decerr_r %0d: got %h, required %h", b, got_q[b], e); end
    end
    for (int b = 0; b < 4; b++) exp_q.push_back(bt(32'h0, 3'd2, b == 3));
    drv_read(4'h3, 32'h10, 8'd3, 3'd2, 2'b10, id);
    for (int b = 0; exp_q.size() > 0; b++) begin
      e = exp_q.pop_front(); vecs++;
      if (got_q[b] !== e) begin errs++; $display("FAIL wrap_r %0d: got %h, required %h", b, got_q[b], e); end
    end
    exp_q.push_back(bt(32'h0, 3'd2, 1'b1));
    drv_read(4'h3, 32'h10, 8'd0, 3'd3, 2'b01, id);
    e = exp_q.pop_front(); vecs++;
    if (got_q[0] !== e) begin errs++; $display("FAIL size_r: got %h, required %h", got_q[0], e); end
    wd_q = '{32'hDEADBEEF}; ws_q = '{4'hF};
    drv_write(4'h4, 32'h10, 8'd0, 3'd2, 2'b10, resp, id);
    vecs++;
    if (resp !== 3'd2) begin errs++; $display("FAIL wrap_b: got %0d, required 2", resp); end
    // boundary burst: first beat is the top word, second falls off the end
    wd_q = '{32'h55AA0001, 32'h55AA0002}; ws_q = '{4'hF, 4'hF};
    drv_write(4'h4, TOP - 4, 8'd1, 3'd2, 2'b01, resp, id);
    vecs++;
    if (resp !== 3'd3) begin errs++; $display("FAIL decerr_b: got %0d, required 3", resp); end
    wd_q = '{32'h1, 32'h2}; ws_q = '{4'hF, 4'hF};
    drv_write(4'h4, 32'h80, 8'd3, 3'd2, 2'b01, resp, id);
    vecs++;
    if (resp !== 3'd2) begin errs++; $display("FAIL len_mismatch_b: got %0d, required 2", resp); end
    exp_q.push_back(bt(32'hA0, 3'd0, 1'b1)); exp_q.push_back(bt(32'h55AA0001, 3'd0, 1'b1));
    drv_read(4'h5, 32'h10, 8'd0, 3'd2, 2'b01, id);
    e = exp_q.pop_front(); vecs++;
    if (got_q[0] !== e) begin errs++; $display("FAIL wrap_nowrite: got %h, required %h", got_q[0], e); end
    drv_read(4'h5, TOP - 4, 8'd0, 3'd2, 2'b01, id);
    e = exp_q.pop_front(); vecs++;
    if (got_q[0] !== e) begin errs++; $display("FAIL top_word: got %h, required %h", got_q[0], e); end
  endtask

  task automatic test_backpressure;
    int n;
    s_awid = 4'h3; s_awaddr = 32'h30; s_awlen = 8'd0; s_awsize = 3'd2; s_awburst = 2'b01;
    s_awvalid = 1'b1;
    n = 0; while (!s_awready && n < BOUND) begin @(negedge clk_i); n++; end
    if (n >= BOUND) tmo("bp_aw");
    @(negedge clk_i); s_awvalid = 1'b0;
    s_wvalid = 1'b1; s_wdata = 32'h5A5A5A5A; s_wstrb = 4'hF; s_wlast = 1'b1;
    n = 0; while (!s_wready && n < BOUND) begin @(negedge clk_i); n++; end
    if (n >= BOUND) tmo("bp_w");
    @(negedge clk_i); s_wvalid = 1'b0; s_wlast = 1'b0;
    n = 0; while (!s_bvalid && n < BOUND) begin @(negedge clk_i); n++; end
    if (n >= BOUND) tmo("bp_b");
    for (int c = 0; c < 5; c++) begin
      vecs++;
      if ({s_bvalid, s_bresp, s_bid, s_awready} !== {1'b1, 3'd0, 4'h3, 1'b0}) begin
        errs++; $display("FAIL b_hold %0d: got bvalid=%b bresp=%0d bid=%h awready=%b, required 1/0/3/0",
                         c, s_bvalid, s_bresp, s_bid, s_awready);
      end
      @(negedge clk_i);
    end
    s_bready = 1'b1; @(negedge clk_i); s_bready = 1'b0;
    vecs++;
    if ({s_bvalid, s_awready} !== 2'b01) begin
      errs++; $display("FAIL b_release: got bvalid/awready %b, required 01", {s_bvalid, s_awready});
    end
    s_arid = 4'h6; s_araddr = 32'h10; s_arlen = 8'd1; s_arsize = 3'd2; s_arburst = 2'b01;
    s_arvalid = 1'b1; s_rready = 1'b0;
    n = 0; while (!s_arready && n < BOUND) begin @(negedge clk_i); n++; end
    if (n >= BOUND) tmo("bp_ar");
    @(negedge clk_i); s_arvalid = 1'b0;
    n = 0; while (!s_rvalid && n < BOUND) begin @(negedge clk_i); n++; end
    if (n >= BOUND) tmo("bp_r0");
    for (int c = 0; c < 4; c++) begin
      vecs++;
      if ({s_rvalid, s_rdata, s_rresp, s_rlast} !== {1'b1, 32'hA0, 3'd0, 1'b0}) begin
        errs++; $display("FAIL r_hold %0d: got rvalid=%b rdata=%h rresp=%0d rlast=%b, required 1/a0/0/0",
                         c, s_rvalid, s_rdata, s_rresp, s_rlast);
      end
      @(negedge clk_i);
    end
    s_rready = 1'b1; @(negedge clk_i);
    n = 0; while (!s_rvalid && n < BOUND) begin @(negedge clk_i); n++; end
    if (n >= BOUND) tmo("bp_r1");
    vecs++;
    if ({s_rdata, s_rlast, s_rid} !== {32'hA1, 1'b1, 4'h6}) begin
      errs++; $display("FAIL r_beat1: got rdata=%h rlast=%b rid=%h, required a1/1/6", s_rdata, s_rlast, s_rid);
    end
    @(negedge clk_i); s_rready = 1'b0;
  endtask

  task automatic test_concurrent;
    logic [2:0] resp; logic [3:0] id, rid; beat_t e;
    wd_q = '{32'hC0, 32'hC1, 32'hC2, 32'hC3}; ws_q = '{4'hF, 4'hF, 4'hF, 4'hF};
    drv_write(4'h7, 32'h40, 8'd3, 3'd2, 2'b01, resp, id);
    wd_q = '{32'hD0, 32'hD1, 32'hD2, 32'hD3};
    // first fetch shares an edge with the first write beat, so it sees the old word
    exp_q.push_back(bt(32'hC0, 3'd0, 1'b0)); exp_q.push_back(bt(32'hD1, 3'd0, 1'b0));
    exp_q.push_back(bt(32'hD2, 3'd0, 1'b0)); exp_q.push_back(bt(32'hD3, 3'd0, 1'b1));
    fork
      drv_write(4'h8, 32'h40, 8'd3, 3'd2, 2'b01, resp, id);
      drv_read(4'hA, 32'h40, 8'd3, 3'd2, 2'b01, rid);
    join
    vecs++;
    if ({resp, rid} !== {3'd0, 4'hA}) begin
      errs++; $display("FAIL conc_ids: got bresp=%0d rid=%h, required 0 / a", resp, rid);
    end
    for (int b = 0; exp_q.size() > 0; b++) begin
      e = exp_q.pop_front(); vecs++;
      if (got_q[b] !== e) begin errs++; $display("FAIL conc_r %0d: got %h, required %h", b, got_q[b], e); end
    end
    for (int b = 0; b < 4; b++) exp_q.push_back(bt(32'hD0 + b, 3'd0, b == 3));
    drv_read(4'hB, 32'h40, 8'd3, 3'd2, 2'b01, rid);
    for (int b = 0; exp_q.size() > 0; b++) begin
      e = exp_q.pop_front(); vecs++;
      if (got_q[b] !== e) begin errs++; $display("FAIL conc_after %0d: got %h, required %h", b, got_q[b], e); end
    end
  endtask

  task automatic test_reset_mid;
    logic [2:0] resp; logic [3:0] id; beat_t e; int n;
    s_awid = 4'h2; s_awaddr = 32'h60; s_awlen = 8'd3; s_awsize = 3'd2; s_awburst = 2'b01;
    s_awvalid = 1'b1;
    n = 0; while (!s_awready && n < BOUND) begin @(negedge clk_i); n++; end
    if (n >= BOUND) tmo("rm_aw");
    @(negedge clk_i); s_awvalid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      s_wvalid = 1'b1; s_wdata = 32'hE0 + b; s_wstrb = 4'hF; s_wlast = 1'b0;
      @(negedge clk_i);
    end
    s_wvalid = 1'b0; s_bready = 1'b1; rst_i = 1'b1;
    @(negedge clk_i); rst_i = 1'b0; #1;
    vecs++;
    if ({s_bvalid, s_awready} !== 2'b01) begin
      errs++; $display("FAIL rst_mid: got bvalid/awready %b, required 01", {s_bvalid, s_awready});
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i); vecs++;
      if (s_bvalid !== 1'b0) begin errs++; $display("FAIL rst_nob %0d: got bvalid=%b, required 0", c, s_bvalid); end
    end
    s_bready = 1'b0;
    wd_q = '{32'hF0, 32'hF1}; ws_q = '{4'hF, 4'hF};
    drv_write(4'h2, 32'h60, 8'd1, 3'd2, 2'b01, resp, id);
    vecs++;
    if (resp !== 3'd0) begin errs++; $display("FAIL rst_new_b: got %0d, required 0", resp); end
    exp_q.push_back(bt(32'hF0, 3'd0, 1'b0)); exp_q.push_back(bt(32'hF1, 3'd0, 1'b1));
    drv_read(4'h2, 32'h60, 8'd1, 3'd2, 2'b01, id);
    for (int b = 0; exp_q.size() > 0; b++) begin
      e = exp_q.pop_front(); vecs++;
      if (got_q[b] !== e) begin errs++; $display("FAIL rst_new_r %0d: got %h, required %h", b, got_q[b], e); end
    end
  endtask

  initial begin
    s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0; s_awvalid = 1'b0;
    s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0; s_wlast = 1'b0; s_bready = 1'b0;
    s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0; s_arvalid = 1'b0;
    s_rready = 1'b0;
    test_reset;
    test_incr;
    test_strobe;
    test_errors;
    test_backpressure;
    test_concurrent;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/axi_sram_slave.md
Name:
axi_sram_slave

Overview:
AXI4 slave SRAM that consumes the CPU subsystem's AXI master port, acting as its instruction/data memory on the far side of the bus. Single-port word array with independent read and write channel FSMs. Supports FIXED/INCR bursts, byte strobes and narrow transfers, with error responses for out-of-range accesses and unsupported bursts.

Parameters:
ID_W, 4, AXI ID width (awid/bid/arid/rid)
ADDR_W, 32, byte address width
DATA_W, 32, data bus width; byte lanes = DATA_W/8
DEPTH, 1024, memory size in DATA_W words; byte range [0, DEPTH*DATA_W/8)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous reset, active-high
s_awid  in  ID_W  write ID
s_awaddr  in  ADDR_W  write start byte address
s_awlen  in  8  beats-1
s_awsize  in  3  log2 bytes/beat
s_awburst  in  2  00 FIXED, 01 INCR, 10 WRAP
s_awvalid  in  1  AW valid
s_awready  out  1  AW ready
s_wdata  in  DATA_W  write data
s_wstrb  in  DATA_W/8  byte enables
s_wvalid  in  1  W valid
s_wlast  in  1  last write beat
s_wready  out  1  W ready
s_bid  out  ID_W  echoed awid
s_bresp  out  3  0 OKAY, 2 SLVERR, 3 DECERR
s_bvalid  out  1  B valid
s_bready  in  1  B ready
s_arid  in  ID_W  read ID
s_araddr  in  ADDR_W  read start byte address
s_arlen  in  8  beats-1
s_arburst  in  2  burst type
s_arsize  in  3  log2 bytes/beat
s_arvalid  in  1  AR valid
s_arready  out  1  AR ready
s_rid  out  ID_W  echoed arid
s_rdata  out  DATA_W  read data
s_rresp  out  3  per-beat response
s_rvalid  out  1  R valid
s_rlast  out  1  last read beat
s_rready  in  1  R ready

Behaviour:
- Reset: all ready/valid/last low, bid/rid/bresp/rresp/rdata 0; both FSMs to IDLE; memory contents not reset. Reset mid-burst aborts silently with no response; awready/arready assert the first cycle after rst_i deasserts.
- Write FSM: W_IDLE (awready=1) -AW handshake, latch id/addr/len/size/burst-> W_DATA (wready=1, one beat/cycle) -beat with wlast=1-> W_RESP (bvalid=1, held until bready) -> W_IDLE. Beat address: FIXED constant; INCR += 1<<size, carrying across lanes/words. Word index = addr>>log2(DATA_W/8). Byte lane i written iff wstrb[i]=1. Burst length is set by wlast; a beat count mismatch vs awlen forces bresp=SLVERR.
- Read FSM: R_IDLE (arready=1) -AR handshake-> R_FETCH (1 cycle, synchronous array read) -> R_DATA (rvalid=1, rdata/rresp/rlast held stable until rready). Handshake on non-last beat -> R_FETCH; on last beat -> R_IDLE. Throughput is 1 beat per 2 cycles; first rvalid is 2 cycles after AR handshake. rlast=1 exactly on beat arlen.
- Errors (sticky per burst, always worst): any beat address >= DEPTH*DATA_W/8 gives DECERR (3); WRAP burst or size > log2(DATA_W/8) gives SLVERR (2). Error beats perform no write, return rdata=0, and still complete the full len+1 beats.
- Simultaneous read and write to the same word in the same cycle: the write updates the array; the read returns pre-write data. The two FSMs never stall each other.

Optional Feature:
AXI_SRAM_ACC_CNT_EN: adds outputs wr_beats_o[31:0] and rd_beats_o[31:0], counting W/R handshakes. Counters are saturating, cleared by rst_i, and include error beats. Without the macro, the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- INCR write awaddr=0x10, len=3, size=2, data 0xA0..0xA3, wstrb=0xF -> bresp=0; INCR read of same -> 4 beats 0xA0..0xA3 with rresp=0, rlast on beat 3, rid=arid.
- Write 0x11223344 to 0x20, then wstrb=0x2 with wdata=0xFFFFFFFF -> read 0x20 returns 0x1122FF44.
- Read araddr=DEPTH*4, len=1 -> 2 beats with rresp=3 and rdata=0; arburst=10 -> rresp=2 on all beats, no memory change.
- Hold bready=0 for 5 cycles, then rready=0 mid-burst -> bvalid and rvalid/rdata held stable, awready stays low until B handshake.
- Concurrent write and read bursts to overlapping addresses -> both complete with no deadlock, and old/new data matches the same-cycle rule.
- Assert rst_i during W_DATA beat 2 -> no bvalid, awready=1 on the cycle after reset, and a new burst completes OKAY.
